mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
Memory-access pipeline stage that consumes the execute stage's load/store and result outputs. It drives a request/grant/response data-memory port, stalls the upstream pipeline while an access is pending, and hands the write-back result to the register-file write stage. Non-memory instructions pass through with one register of latency. Loads and stores take a variable number of cycles, set by the memory's grant and response timing.

Parameters:
DMEM_ADDR_WIDTH, 12, data memory address width
DMEM_WORD_WIDTH, 16, data memory word width
IALU_WORD_WIDTH, 16, result word width (equals DMEM_WORD_WIDTH)
PC_WIDTH, 12, program counter width
PMEM_WORD_WIDTH, 16, instruction word width
REG_IDX_WIDTH, 4, register index width
TIMEOUT_WIDTH, 4, watchdog counter width; access aborts after 2^TIMEOUT_WIDTH-1 waiting cycles

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
in_act_load_dmem  in  1  instruction is a load
in_act_store_dmem  in  1  instruction is a store
in_act_write_res_to_reg  in  1  instruction writes a register
in_dmem_rd_addr  in  DMEM_ADDR_WIDTH  load address
in_dmem_wr_addr  in  DMEM_ADDR_WIDTH  store address
in_dmem_wr_word  in  DMEM_WORD_WIDTH  store data
in_instr  in  PMEM_WORD_WIDTH  instruction word
in_pc  in  PC_WIDTH  instruction PC
in_res  in  IALU_WORD_WIDTH  ALU result
in_res_reg_idx  in  REG_IDX_WIDTH  destination register
in_dmem_gnt  in  1  memory accepted the current request
in_dmem_rvalid  in  1  read data valid
in_dmem_rdata  in  DMEM_WORD_WIDTH  read data
out_dmem_req  out  1  request valid
out_dmem_we  out  1  1 = write, 0 = read
out_dmem_addr  out  DMEM_ADDR_WIDTH  request address
out_dmem_wdata  out  DMEM_WORD_WIDTH  write data
out_stall  out  1  upstream must hold its outputs and registers
out_act_write_res_to_reg  out  1  write-back enable
out_res  out  IALU_WORD_WIDTH  write-back data
out_res_reg_idx  out  REG_IDX_WIDTH  write-back register
out_instr  out  PMEM_WORD_WIDTH  instruction to the next stage
out_pc  out  PC_WIDTH  PC to the next stage
out_err  out  1  sticky error flag

Behaviour:
- Reset:
  - All input registers, rdata_ff, the watchdog counter and out_err clear to 0; the state machine goes to IDLE.
  - All outputs are 0 during and after reset until the first instruction arrives.
  - A reset asserted mid-access abandons the access immediately; no request is re-issued.
- Input register: samples all in_* signals on every rising edge where out_stall=0, and holds them while out_stall=1.
- States:
  - IDLE: the sampled instruction has no memory operation, or has a newly sampled one.
  - REQ: request issued, waiting for grant.
  - RSP: load granted, waiting for rvalid.
  - DONE: load data captured.
- Non-memory instruction (IDLE, load_ff=0, store_ff=0):
  - Outputs equal the _ff values in the cycle after sampling; stall=0.
- Memory instruction sampled:
  - The first cycle behaves as REQ: out_dmem_req=1.
  - Address is wr_addr_ff for a store, rd_addr_ff for a load; out_dmem_we=store_ff; out_dmem_wdata=wr_word_ff for a store, else 0.
  - Request signals stay stable until gnt is seen.
- Store:
  - gnt=1 completes the store; state goes to IDLE; out_stall = req & ~gnt (combinational path from gnt).
  - No write-back: out_act_write_res_to_reg=0.
- Load:
  - gnt moves the state to RSP; out_stall=1 in REQ and RSP.
  - rvalid in RSP captures rdata into rdata_ff; state goes to DONE.
  - In DONE: out_stall=0, out_res=rdata_ff, write-back enable = act_write_res_to_reg_ff; state goes to IDLE or REQ per the newly sampled instruction.
  - Minimum load: gnt in the first cycle, rvalid in the next, result in the third; 2 stall cycles.
- Bubble outputs:
  - While stalled: out_act_write_res_to_reg=0, out_res_reg_idx=0, out_res=0, out_instr=0, out_pc=0.
  - While not stalled, including after a completed store: out_instr and out_pc pass through.
- load_ff and store_ff both set: illegal.
  - The store is performed, the load is dropped, out_err is set.
- rvalid outside RSP: ignored; out_err is set.
- Watchdog:
  - The counter increments each cycle in REQ or RSP and clears on gnt (REQ) and rvalid (RSP).
  - At all-ones: the access is aborted, out_err is set, and the state goes to IDLE for a store, or to DONE with rdata_ff=0 for a load.
  - out_dmem_req drops in the abort cycle.
- out_err is cleared only by reset.

Decomposition:
- Shared package: state encodings (IDLE, REQ, RSP, DONE) and the default width constants shared with the pipeline stages.
- One natural sub-module, mem_access_watchdog: a counter with clear, enable and expire signals.

Test Plan:
- ALU instruction with res=0x1234, reg_idx=3, write=1 -> next cycle out_res=0x1234, out_res_reg_idx=3, write=1, stall=0, req=0.
- Store of 0xBEEF to 0x040 with gnt in the first cycle -> req=1, we=1, addr=0x040, wdata=0xBEEF for 1 cycle; stall=0; write=0.
- Load from 0x010; gnt after 2 cycles; rvalid with 0x00AA 3 cycles later -> stall high 5 cycles; then out_res=0x00AA, reg written, input held throughout.
- Load with gnt never asserted -> abort after 15 waiting cycles; out_err=1; write-back of 0; pipeline resumes.
- load=store=1, and separately a spurious rvalid in IDLE -> store issued, no read; out_err=1 in both cases.
- Reset pulse while in RSP -> all outputs 0, state IDLE, stall=0; a later rvalid sets out_err.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared constants for the memory-access stage: default bus widths and FSM state codes.
// No logic, so there is no latency or backpressure here.
// The stage and its watchdog import this package.
package mem_access_pkg;

    localparam int DMEM_ADDR_WIDTH_DEF = 12;
    localparam int DMEM_WORD_WIDTH_DEF = 16;
    localparam int IALU_WORD_WIDTH_DEF = 16;
    localparam int PC_WIDTH_DEF        = 12;
    localparam int PMEM_WORD_WIDTH_DEF = 16;
    localparam int REG_IDX_WIDTH_DEF   = 4;
    localparam int TIMEOUT_WIDTH_DEF   = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RSP  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/mem_access_watchdog.sv
// Wait-cycle counter that flags an expired memory access once it reaches all-ones.
// Latency: expire is combinational from the count; the count advances one per enabled cycle.
// Backpressure: none; clr has priority over en.
module mem_access_watchdog
    import mem_access_pkg::*;
#(
    parameter int WIDTH = TIMEOUT_WIDTH_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = en & (&cnt);

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: issues loads/stores on a req/gnt/rvalid port and hands results to write-back.
// Latency: 1 cycle for non-memory ops; loads/stores last until grant/response or watchdog abort.
// Backpressure: out_stall holds the upstream stage; for stores it follows gnt combinationally.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int DMEM_ADDR_WIDTH = DMEM_ADDR_WIDTH_DEF,
    parameter int DMEM_WORD_WIDTH = DMEM_WORD_WIDTH_DEF,
    parameter int IALU_WORD_WIDTH = IALU_WORD_WIDTH_DEF,
    parameter int PC_WIDTH        = PC_WIDTH_DEF,
    parameter int PMEM_WORD_WIDTH = PMEM_WORD_WIDTH_DEF,
    parameter int REG_IDX_WIDTH   = REG_IDX_WIDTH_DEF,
    parameter int TIMEOUT_WIDTH   = TIMEOUT_WIDTH_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_act_load_dmem,
    input  logic                       in_act_store_dmem,
    input  logic                       in_act_write_res_to_reg,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_dmem_rd_addr,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_dmem_wr_addr,
    input  logic [DMEM_WORD_WIDTH-1:0] in_dmem_wr_word,
    input  logic [PMEM_WORD_WIDTH-1:0] in_instr,
    input  logic [PC_WIDTH-1:0]        in_pc,
    input  logic [IALU_WORD_WIDTH-1:0] in_res,
    input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
    input  logic                       in_dmem_gnt,
    input  logic                       in_dmem_rvalid,
    input  logic [DMEM_WORD_WIDTH-1:0] in_dmem_rdata,
    output logic                       out_dmem_req,
    output logic                       out_dmem_we,
    output logic [DMEM_ADDR_WIDTH-1:0] out_dmem_addr,
    output logic [DMEM_WORD_WIDTH-1:0] out_dmem_wdata,
    output logic                       out_stall,
    output logic                       out_act_write_res_to_reg,
    output logic [IALU_WORD_WIDTH-1:0] out_res,
    output logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx,
    output logic [PMEM_WORD_WIDTH-1:0] out_instr,
    output logic [PC_WIDTH-1:0]        out_pc,
    output logic                       out_err
);

    logic                       load_ff;
    logic                       store_ff;
    logic                       wres_ff;
    logic [DMEM_ADDR_WIDTH-1:0] rd_addr_ff;
    logic [DMEM_ADDR_WIDTH-1:0] wr_addr_ff;
    logic [DMEM_WORD_WIDTH-1:0] wr_word_ff;
    logic [PMEM_WORD_WIDTH-1:0] instr_ff;
    logic [PC_WIDTH-1:0]        pc_ff;
    logic [IALU_WORD_WIDTH-1:0] res_ff;
    logic [REG_IDX_WIDTH-1:0]   res_reg_idx_ff;
    logic [DMEM_WORD_WIDTH-1:0] rdata_ff;
    logic [1:0]                 state;
    logic                       err_ff;

    logic in_req;
    logic in_rsp;
    logic in_done;
    logic req;
    logic stall;
    logic expire;
    logic wd_clr;

    assign in_req  = (state == ST_REQ);
    assign in_rsp  = (state == ST_RSP);
    assign in_done = (state == ST_DONE);

    // Store wins when both load and store are flagged; the load half is dropped.
    assign req   = in_req & ~expire;
    assign stall = in_rsp | (in_req & ~store_ff) | (req & store_ff & ~in_dmem_gnt);

    assign wd_clr = ~(in_req | in_rsp) | (in_req & in_dmem_gnt) | (in_rsp & in_dmem_rvalid) | expire;

    mem_access_watchdog #(
        .WIDTH (TIMEOUT_WIDTH)
    ) u_wd (
        .clock  (clock),
        .reset  (reset),
        .clr    (wd_clr),
        .en     (in_req | in_rsp),
        .expire (expire)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            load_ff        <= 1'b0;
            store_ff       <= 1'b0;
            wres_ff        <= 1'b0;
            rd_addr_ff     <= '0;
            wr_addr_ff     <= '0;
            wr_word_ff     <= '0;
            instr_ff       <= '0;
            pc_ff          <= '0;
            res_ff         <= '0;
            res_reg_idx_ff <= '0;
            rdata_ff       <= '0;
            state          <= ST_IDLE;
        end else if (!stall) begin
            load_ff        <= in_act_load_dmem;
            store_ff       <= in_act_store_dmem;
            wres_ff        <= in_act_write_res_to_reg;
            rd_addr_ff     <= in_dmem_rd_addr;
            wr_addr_ff     <= in_dmem_wr_addr;
            wr_word_ff     <= in_dmem_wr_word;
            instr_ff       <= in_instr;
            pc_ff          <= in_pc;
            res_ff         <= in_res;
            res_reg_idx_ff <= in_res_reg_idx;
            state          <= (in_act_load_dmem | in_act_store_dmem) ? ST_REQ : ST_IDLE;
        end else if (in_req & ~store_ff) begin
            if (expire) begin
                rdata_ff <= '0;
                state    <= ST_DONE;
            end else if (in_dmem_gnt) begin
                state <= ST_RSP;
            end
        end else if (in_rsp) begin
            if (expire) begin
                rdata_ff <= '0;
                state    <= ST_DONE;
            end else if (in_dmem_rvalid) begin
                rdata_ff <= in_dmem_rdata;
                state    <= ST_DONE;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_ff <= 1'b0;
        end else if ((in_dmem_rvalid & ~in_rsp) | (in_req & load_ff & store_ff) | expire) begin
            err_ff <= 1'b1;
        end
    end

    assign out_err = err_ff;

    always_comb begin
        out_dmem_req             = req;
        out_dmem_we              = req & store_ff;
        out_dmem_addr            = '0;
        out_dmem_wdata           = '0;
        out_stall                = stall;
        out_act_write_res_to_reg = 1'b0;
        out_res                  = '0;
        out_res_reg_idx          = '0;
        out_instr                = '0;
        out_pc                   = '0;
        if (req) begin
            out_dmem_addr = store_ff ? wr_addr_ff : rd_addr_ff;
            if (store_ff) begin
                out_dmem_wdata = wr_word_ff;
            end
        end
        // A finished store leaves state in REQ; it passes instr/pc but writes nothing back.
        if (!stall) begin
            out_instr = instr_ff;
            out_pc    = pc_ff;
            if (in_done) begin
                out_act_write_res_to_reg = wres_ff;
                out_res                  = rdata_ff;
                out_res_reg_idx          = res_reg_idx_ff;
            end else if (state == ST_IDLE) begin
                out_act_write_res_to_reg = wres_ff;
                out_res                  = res_ff;
                out_res_reg_idx          = res_reg_idx_ff;
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed table of instructions, reset corner sequences, then random traffic.
// Expected outputs come from per-instruction timing rules (grant/response delays), not from the FSM.
module tb_mem_access;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_act_load_dmem, in_act_store_dmem, in_act_write_res_to_reg;
    logic [11:0] in_dmem_rd_addr, in_dmem_wr_addr, in_pc;
    logic [15:0] in_dmem_wr_word, in_instr, in_res, in_dmem_rdata;
    logic [3:0]  in_res_reg_idx;
    logic        in_dmem_gnt, in_dmem_rvalid;
    logic        out_dmem_req, out_dmem_we, out_stall, out_act_write_res_to_reg, out_err;
    logic [11:0] out_dmem_addr, out_pc;
    logic [15:0] out_dmem_wdata, out_res, out_instr;
    logic [3:0]  out_res_reg_idx;

    always #5 clock = ~clock;

    mem_access dut (
        .clock                    (clock),
        .reset                    (reset),
        .in_act_load_dmem         (in_act_load_dmem),
        .in_act_store_dmem        (in_act_store_dmem),
        .in_act_write_res_to_reg  (in_act_write_res_to_reg),
        .in_dmem_rd_addr          (in_dmem_rd_addr),
        .in_dmem_wr_addr          (in_dmem_wr_addr),
        .in_dmem_wr_word          (in_dmem_wr_word),
        .in_instr                 (in_instr),
        .in_pc                    (in_pc),
        .in_res                   (in_res),
        .in_res_reg_idx           (in_res_reg_idx),
        .in_dmem_gnt              (in_dmem_gnt),
        .in_dmem_rvalid           (in_dmem_rvalid),
        .in_dmem_rdata            (in_dmem_rdata),
        .out_dmem_req             (out_dmem_req),
        .out_dmem_we              (out_dmem_we),
        .out_dmem_addr            (out_dmem_addr),
        .out_dmem_wdata           (out_dmem_wdata),
        .out_stall                (out_stall),
        .out_act_write_res_to_reg (out_act_write_res_to_reg),
        .out_res                  (out_res),
        .out_res_reg_idx          (out_res_reg_idx),
        .out_instr                (out_instr),
        .out_pc                   (out_pc),
        .out_err                  (out_err)
    );

    typedef struct packed {
        logic        req;
        logic        we;
        logic [11:0] addr;
        logic [15:0] wdata;
        logic        stall;
        logic        act;
        logic [15:0] res;
        logic [3:0]  idx;
        logic [15:0] instr;
        logic [11:0] pc;
    } obs_t;

    // g: cycle index of grant (>14 = never); r: cycles from grant to rvalid (>15 = never).
    typedef struct {
        logic        ld, st, w;
        logic [11:0] rd, wa;
        logic [15:0] wd, ins;
        logic [11:0] pc;
        logic [15:0] res;
        logic [3:0]  idx;
        int          g, r;
        logic [15:0] rdata;
        bit          spur;
    } instr_t;

    typedef struct {
        instr_t      t;
        int          exp_stalls;
        logic        exp_act;
        logic [15:0] exp_res;
        logic        exp_err;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic exp_err = 1'b0;

    function automatic obs_t get_obs();
        obs_t o;
        o.req = out_dmem_req;  o.we = out_dmem_we;  o.addr = out_dmem_addr;  o.wdata = out_dmem_wdata;
        o.stall = out_stall;   o.act = out_act_write_res_to_reg;  o.res = out_res;
        o.idx = out_res_reg_idx;  o.instr = out_instr;  o.pc = out_pc;
        return o;
    endfunction

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic instr_t mk(input logic ld, input logic st, input logic w,
                                  input logic [11:0] rd, input logic [11:0] wa, input logic [15:0] wd,
                                  input logic [15:0] ins, input logic [11:0] pc, input logic [15:0] res,
                                  input logic [3:0] idx, input int g, input int r,
                                  input logic [15:0] rdata, input bit spur);
        instr_t t;
        t.ld = ld; t.st = st; t.w = w; t.rd = rd; t.wa = wa; t.wd = wd; t.ins = ins; t.pc = pc;
        t.res = res; t.idx = idx; t.g = g; t.r = r; t.rdata = rdata; t.spur = spur;
        return t;
    endfunction

    function automatic bit timed_out(input instr_t t);
        if (t.st) return t.g > 14;
        if (t.ld) return (t.g > 14) || (t.r > 15);
        return 1'b0;
    endfunction

    // Expected outputs in cycle c after the instruction is sampled, from the access timing rules.
    function automatic obs_t model(input instr_t t, input int c, output bit last);
        obs_t        o;
        int          lastc, req_end;
        logic [15:0] data;
        o = '0; data = '0; lastc = 0; req_end = -1;
        if (t.st) begin
            req_end = (t.g > 14) ? 14 : t.g;
            lastc   = (t.g > 14) ? 15 : t.g;
        end else if (t.ld) begin
            if (t.g > 14) begin
                req_end = 14; lastc = 16;
            end else begin
                req_end = t.g;
                if (t.r > 15) lastc = t.g + 17;
                else begin lastc = t.g + t.r + 1; data = t.rdata; end
            end
        end
        o.stall = (c < lastc);
        if (c <= req_end) begin
            o.req = 1'b1; o.we = t.st; o.addr = t.st ? t.wa : t.rd; o.wdata = t.st ? t.wd : 16'h0;
        end
        if (c == lastc) begin
            o.instr = t.ins; o.pc = t.pc;
            if (!t.st) begin
                o.act = t.w; o.idx = t.idx; o.res = t.ld ? data : t.res;
            end
        end
        last = (c == lastc);
        return o;
    endfunction

    task automatic drive_in(input instr_t t);
        in_act_load_dmem = t.ld;  in_act_store_dmem = t.st;  in_act_write_res_to_reg = t.w;
        in_dmem_rd_addr = t.rd;   in_dmem_wr_addr = t.wa;    in_dmem_wr_word = t.wd;
        in_instr = t.ins;  in_pc = t.pc;  in_res = t.res;  in_res_reg_idx = t.idx;
    endtask

    task automatic drive_junk();
        in_act_load_dmem = 1'($urandom);  in_act_store_dmem = 1'($urandom);
        in_act_write_res_to_reg = 1'($urandom);
        in_dmem_rd_addr = 12'($urandom);  in_dmem_wr_addr = 12'($urandom);  in_dmem_wr_word = 16'($urandom);
        in_instr = 16'($urandom);  in_pc = 12'($urandom);  in_res = 16'($urandom);
        in_res_reg_idx = 4'($urandom);
    endtask

    task automatic zero_in();
        drive_in(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        in_dmem_gnt = 1'b0;  in_dmem_rvalid = 1'b0;  in_dmem_rdata = '0;
    endtask

    // Starts and ends at a falling edge; upstream inputs are scrambled while stalled.
    task automatic do_instr(input instr_t t, output int stalls, output obs_t fin);
        obs_t e;
        bit   last;
        stalls = 0;
        fin    = '0;
        drive_in(t);
        @(posedge clock); #1;
        for (int c = 0; c < 64; c++) begin
            in_dmem_gnt    = (t.ld | t.st) && (c == t.g);
            in_dmem_rvalid = (t.ld && !t.st && (c == t.g + t.r)) || (t.spur && c == 0);
            in_dmem_rdata  = in_dmem_rvalid ? t.rdata : 16'($urandom);
            @(negedge clock);
            if (c == 0) check_val("err_state", out_err, exp_err);
            e = model(t, c, last);
            check_obs($sformatf("cycle%0d_pc%0h", c, t.pc), get_obs(), e);
            if (out_stall) stalls++;
            if (last) begin
                fin = get_obs();
                break;
            end
            drive_junk();
            @(posedge clock); #1;
        end
        if ((t.ld & t.st) || timed_out(t) || (t.spur && !t.ld && !t.st)) exp_err = 1'b1;
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        zero_in();
        @(negedge clock);
        reset   = 1'b0;
        exp_err = 1'b0;
    endtask

    function automatic instr_t rnd_instr();
        int     kind;
        instr_t t;
        kind = $urandom_range(0, 9);
        t = mk(kind >= 6, (kind == 4) || (kind == 5) || (kind == 9), 1'($urandom),
               12'($urandom), 12'($urandom), 16'($urandom), 16'($urandom), 12'($urandom),
               16'($urandom), 4'($urandom),
               ($urandom_range(0, 15) == 0) ? 31 : $urandom_range(0, 3),
               ($urandom_range(0, 15) == 0) ? 31 : $urandom_range(1, 4),
               16'($urandom), 1'b0);
        t.spur = (kind < 4) && ($urandom_range(0, 7) == 0);
        return t;
    endfunction

    vec_t   tbl[6];
    instr_t nop;

    initial begin
        int   s;
        obs_t f;
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[0] = '{mk(0, 0, 1, 0, 0, 0, 16'hA001, 12'h100, 16'h1234, 4'd3, 0, 0, 0, 0), 0, 1'b1, 16'h1234, 1'b0};
        tbl[1] = '{mk(0, 1, 1, 0, 12'h040, 16'hBEEF, 16'hA002, 12'h101, 16'h7777, 4'd9, 0, 0, 0, 0), 0, 1'b0, 16'h0000, 1'b0};
        tbl[2] = '{mk(1, 0, 1, 12'h010, 0, 0, 16'hA003, 12'h102, 16'h1111, 4'd5, 1, 3, 16'h00AA, 0), 5, 1'b1, 16'h00AA, 1'b0};
        tbl[3] = '{mk(1, 0, 0, 12'h020, 0, 0, 16'hA004, 12'h103, 16'h2222, 4'd6, 0, 1, 16'h5555, 0), 2, 1'b0, 16'h5555, 1'b0};
        tbl[4] = '{mk(0, 1, 0, 0, 12'h0FF, 16'h0123, 16'hA005, 12'h104, 16'h3333, 4'd2, 3, 0, 0, 0), 3, 1'b0, 16'h0000, 1'b0};
        tbl[5] = '{mk(1, 1, 1, 12'h011, 12'h044, 16'hCAFE, 16'hA006, 12'h105, 16'h4444, 4'd1, 0, 0, 0, 0), 0, 1'b0, 16'h0000, 1'b1};

        reset = 1'b1;
        zero_in();
        @(negedge clock);
        @(negedge clock);
        check_obs("reset_outputs", get_obs(), '0);
        check_val("reset_err", out_err, 0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            do_instr(tbl[i].t, s, f);
            check_val($sformatf("vec%0d_stalls", i), s, tbl[i].exp_stalls);
            check_val($sformatf("vec%0d_act", i), f.act, tbl[i].exp_act);
            check_val($sformatf("vec%0d_res", i), f.res, tbl[i].exp_res);
            do_instr(nop, s, f);
            check_val($sformatf("vec%0d_err", i), out_err, tbl[i].exp_err);
        end

        // Load whose grant never arrives: watchdog abort, zero write-back, then the pipe resumes.
        pulse_reset();
        do_instr(mk(1, 0, 1, 12'h055, 0, 0, 16'hA007, 12'h106, 16'h5151, 4'd4, 31, 1, 16'hFFFF, 0), s, f);
        check_val("tmo_stalls", s, 16);
        check_val("tmo_act", f.act, 1);
        check_val("tmo_res", f.res, 0);
        do_instr(nop, s, f);
        check_val("tmo_err", out_err, 1);
        check_val("tmo_resume_stall", s, 0);

        // Reset in the middle of a load response wait, then a stray rvalid.
        drive_in(mk(1, 0, 1, 12'h033, 0, 0, 16'hB00B, 12'h1F0, 0, 4'd7, 0, 0, 0, 0));
        @(posedge clock); #1;
        in_dmem_gnt = 1'b1;
        @(negedge clock);
        check_val("rsp_req", out_dmem_req, 1);
        @(posedge clock); #1;
        in_dmem_gnt = 1'b0;
        @(negedge clock);
        check_val("rsp_stall", out_stall, 1);
        reset = 1'b1;
        zero_in();
        #1;
        check_obs("rst_mid_outputs", get_obs(), '0);
        check_val("rst_mid_err", out_err, 0);
        @(negedge clock);
        reset   = 1'b0;
        exp_err = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        check_obs("post_rst_no_reissue", get_obs(), '0);
        @(posedge clock); #1;
        in_dmem_rvalid = 1'b1;
        in_dmem_rdata  = 16'h9999;
        @(negedge clock);
        check_obs("stray_rvalid_ignored", get_obs(), '0);
        @(posedge clock); #1;
        in_dmem_rvalid = 1'b0;
        @(negedge clock);
        check_val("stray_rvalid_err", out_err, 1);
        exp_err = 1'b1;

        pulse_reset();
        for (int i = 0; i < 200; i++) begin
            if (i % 50 == 49) pulse_reset();
            do_instr(rnd_instr(), s, f);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
